// File: rtl/multicycle_control_pkg.sv
// Shared types and encodings for the multi-cycle datapath main control FSM.
package multicycle_control_pkg;

  localparam int unsigned OP_W   = 6;
  localparam int unsigned WAIT_W = 16;

  typedef enum logic [3:0] {
    IDLE,
    FETCH,
    DECODE,
    MEM_ADDR,
    MEM_READ,
    MEM_WB,
    MEM_WRITE,
    R_EXEC,
    R_WB,
    BRANCH,
    JUMP,
    ADDI_EXEC,
    ADDI_WB,
    TRAP
  } mc_state_t;

  localparam logic [OP_W-1:0] OP_RTYPE = 6'b000000;
  localparam logic [OP_W-1:0] OP_LW    = 6'b100011;
  localparam logic [OP_W-1:0] OP_SW    = 6'b101011;
  localparam logic [OP_W-1:0] OP_BEQ   = 6'b000100;
  localparam logic [OP_W-1:0] OP_J     = 6'b000010;
  localparam logic [OP_W-1:0] OP_ADDI  = 6'b001000;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  localparam logic [1:0] ALUSRCB_B       = 2'b00;
  localparam logic [1:0] ALUSRCB_FOUR    = 2'b01;
  localparam logic [1:0] ALUSRCB_IMM     = 2'b10;
  localparam logic [1:0] ALUSRCB_IMM_SH2 = 2'b11;

  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

  typedef struct packed {
    logic       pc_write;
    logic       pc_write_cond;
    logic       ior_d;
    logic       mem_read;
    logic       mem_write;
    logic       ir_write;
    logic       mem_to_reg;
    logic       reg_dst;
    logic       reg_write;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
    logic [1:0] pc_source;
    logic       instr_done;
  } mc_ctrl_t;

  // States that stall on the memory ready handshake.
  function automatic logic is_mem_state(mc_state_t s);
    return (s == FETCH) || (s == MEM_READ) || (s == MEM_WRITE);
  endfunction

endpackage

// File: rtl/multicycle_ctrl_decode.sv
// State (plus mem_ready qualification) to datapath control word; purely combinational.
module multicycle_ctrl_decode
  import multicycle_control_pkg::*;
(
  input  mc_state_t state,
  input  logic      mem_ready,
  output mc_ctrl_t  ctrl
);

  always_comb begin
    ctrl = '0;
    case (state)
      FETCH: begin
        ctrl.mem_read  = 1'b1;
        ctrl.alu_src_b = ALUSRCB_FOUR;
        ctrl.alu_op    = ALUOP_ADD;
        ctrl.pc_source = PCSRC_ALU;
        ctrl.ir_write  = mem_ready;
        ctrl.pc_write  = mem_ready;
      end
      DECODE: begin
        ctrl.alu_src_b = ALUSRCB_IMM_SH2;
        ctrl.alu_op    = ALUOP_ADD;
      end
      MEM_ADDR, ADDI_EXEC: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_src_b = ALUSRCB_IMM;
        ctrl.alu_op    = ALUOP_ADD;
      end
      MEM_READ: begin
        ctrl.mem_read = 1'b1;
        ctrl.ior_d    = 1'b1;
      end
      MEM_WB: begin
        ctrl.reg_write  = 1'b1;
        ctrl.mem_to_reg = 1'b1;
        ctrl.instr_done = 1'b1;
      end
      MEM_WRITE: begin
        ctrl.mem_write  = 1'b1;
        ctrl.ior_d      = 1'b1;
        ctrl.instr_done = mem_ready;
      end
      R_EXEC: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_src_b = ALUSRCB_B;
        ctrl.alu_op    = ALUOP_FUNCT;
      end
      R_WB: begin
        ctrl.reg_write  = 1'b1;
        ctrl.reg_dst    = 1'b1;
        ctrl.instr_done = 1'b1;
      end
      BRANCH: begin
        ctrl.alu_src_a     = 1'b1;
        ctrl.alu_src_b     = ALUSRCB_B;
        ctrl.alu_op        = ALUOP_SUB;
        ctrl.pc_write_cond = 1'b1;
        ctrl.pc_source     = PCSRC_ALUOUT;
        ctrl.instr_done    = 1'b1;
      end
      JUMP: begin
        ctrl.pc_write   = 1'b1;
        ctrl.pc_source  = PCSRC_JUMP;
        ctrl.instr_done = 1'b1;
      end
      ADDI_WB: begin
        ctrl.reg_write  = 1'b1;
        ctrl.instr_done = 1'b1;
      end
      default: ctrl = '0;
    endcase
  end

endmodule

// File: rtl/multicycle_control.sv
// Main control FSM for the multi-cycle datapath: sequences fetch, decode, execute, memory, writeback.
// MC_ILLEGAL_TRAP_EN: unrecognised opcodes trap (adds illegal_op); otherwise they retire as NOPs.
module multicycle_control
  import multicycle_control_pkg::*;
#(
  parameter int unsigned MEM_TIMEOUT = 255
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [OP_W-1:0] opcode,
  input  logic            zero,
  input  logic            mem_ready,
  output logic            pc_write,
  output logic            pc_write_cond,
  output logic            ior_d,
  output logic            mem_read,
  output logic            mem_write,
  output logic            ir_write,
  output logic            mem_to_reg,
  output logic            reg_dst,
  output logic            reg_write,
  output logic            alu_src_a,
  output logic [1:0]      alu_src_b,
  output logic [1:0]      alu_op,
  output logic [1:0]      pc_source,
  output logic            instr_done,
  output logic            mem_timeout
`ifdef MC_ILLEGAL_TRAP_EN
  ,
  output logic            illegal_op
`endif
);

  mc_state_t         state_q, state_d;
  logic [WAIT_W-1:0] wait_cnt_q;
  logic              mem_wait;
  logic              op_legal;
  mc_ctrl_t          ctrl;

  // The branch decision is made by the datapath PC-load gate from pc_write_cond and zero.
  logic unused_zero;
  assign unused_zero = zero;

  assign op_legal = (opcode == OP_LW)    || (opcode == OP_SW)   ||
                    (opcode == OP_RTYPE) || (opcode == OP_BEQ)  ||
                    (opcode == OP_J)     || (opcode == OP_ADDI);

  assign mem_wait = is_mem_state(state_q) && !mem_ready;

  // State register, wait counter and sticky timeout flag.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      wait_cnt_q  <= '0;
      mem_timeout <= 1'b0;
    end else begin
      state_q <= state_d;
      if (state_d != state_q) begin
        wait_cnt_q <= '0;
      end else if (mem_wait && (wait_cnt_q != {WAIT_W{1'b1}})) begin
        wait_cnt_q <= wait_cnt_q + WAIT_W'(1);
      end
      if (mem_wait && (wait_cnt_q >= WAIT_W'(MEM_TIMEOUT))) begin
        mem_timeout <= 1'b1;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:      state_d = FETCH;
      FETCH:     if (mem_ready) state_d = DECODE;
      DECODE: begin
        case (opcode)
          OP_LW, OP_SW: state_d = MEM_ADDR;
          OP_RTYPE:     state_d = R_EXEC;
          OP_BEQ:       state_d = BRANCH;
          OP_J:         state_d = JUMP;
          OP_ADDI:      state_d = ADDI_EXEC;
`ifdef MC_ILLEGAL_TRAP_EN
          default:      state_d = TRAP;
`else
          default:      state_d = FETCH;
`endif
        endcase
      end
      MEM_ADDR:  state_d = (opcode == OP_LW) ? MEM_READ : MEM_WRITE;
      MEM_READ:  if (mem_ready) state_d = MEM_WB;
      MEM_WRITE: if (mem_ready) state_d = FETCH;
      R_EXEC:    state_d = R_WB;
      ADDI_EXEC: state_d = ADDI_WB;
      MEM_WB, R_WB, BRANCH, JUMP, ADDI_WB: state_d = FETCH;
      TRAP:      state_d = TRAP;
      default:   state_d = IDLE;
    endcase
  end

  multicycle_ctrl_decode u_decode (
    .state     (state_q),
    .mem_ready (mem_ready),
    .ctrl      (ctrl)
  );

  assign pc_write      = ctrl.pc_write;
  assign pc_write_cond = ctrl.pc_write_cond;
  assign ior_d         = ctrl.ior_d;
  assign mem_read      = ctrl.mem_read;
  assign mem_write     = ctrl.mem_write;
  assign ir_write      = ctrl.ir_write;
  assign mem_to_reg    = ctrl.mem_to_reg;
  assign reg_dst       = ctrl.reg_dst;
  assign reg_write     = ctrl.reg_write;
  assign alu_src_a     = ctrl.alu_src_a;
  assign alu_src_b     = ctrl.alu_src_b;
  assign alu_op        = ctrl.alu_op;
  assign pc_source     = ctrl.pc_source;

`ifdef MC_ILLEGAL_TRAP_EN
  assign instr_done = ctrl.instr_done;
  assign illegal_op = (state_q == TRAP);
`else
  // An unrecognised opcode retires as a NOP in its DECODE cycle.
  assign instr_done = ctrl.instr_done | ((state_q == DECODE) & ~op_legal);
`endif

endmodule

// File: tb/tb_multicycle_control.sv
// Scoreboard bench for multicycle_control: expected control words queued per driven cycle, checked at negedge.
module tb_multicycle_control;

  localparam logic O = 1'b0;
  localparam logic I = 1'b1;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_BAD   = 6'b111111;

  function automatic logic [16:0] cw(input logic pcw, input logic pcwc, input logic iord,
                                     input logic mr, input logic mw, input logic irw,
                                     input logic m2r, input logic rdst, input logic rw,
                                     input logic asa, input logic [1:0] asb,
                                     input logic [1:0] aop, input logic [1:0] psrc,
                                     input logic done);
    return {pcw, pcwc, iord, mr, mw, irw, m2r, rdst, rw, asa, asb, aop, psrc, done};
  endfunction

  localparam logic [16:0] W_ZERO       = 17'd0;
  localparam logic [16:0] W_FETCH_WAIT = cw(O,O,O,I,O,O,O,O,O,O,2'b01,2'b00,2'b00,O);
  localparam logic [16:0] W_FETCH_GO   = cw(I,O,O,I,O,I,O,O,O,O,2'b01,2'b00,2'b00,O);
  localparam logic [16:0] W_DECODE     = cw(O,O,O,O,O,O,O,O,O,O,2'b11,2'b00,2'b00,O);
  localparam logic [16:0] W_DECODE_NOP = cw(O,O,O,O,O,O,O,O,O,O,2'b11,2'b00,2'b00,I);
  localparam logic [16:0] W_MEM_ADDR   = cw(O,O,O,O,O,O,O,O,O,I,2'b10,2'b00,2'b00,O);
  localparam logic [16:0] W_MEM_RD     = cw(O,O,I,I,O,O,O,O,O,O,2'b00,2'b00,2'b00,O);
  localparam logic [16:0] W_MEM_WB     = cw(O,O,O,O,O,O,I,O,I,O,2'b00,2'b00,2'b00,I);
  localparam logic [16:0] W_MEM_WR     = cw(O,O,I,O,I,O,O,O,O,O,2'b00,2'b00,2'b00,O);
  localparam logic [16:0] W_MEM_WR_GO  = cw(O,O,I,O,I,O,O,O,O,O,2'b00,2'b00,2'b00,I);
  localparam logic [16:0] W_R_EXEC     = cw(O,O,O,O,O,O,O,O,O,I,2'b00,2'b10,2'b00,O);
  localparam logic [16:0] W_R_WB       = cw(O,O,O,O,O,O,O,I,I,O,2'b00,2'b00,2'b00,I);
  localparam logic [16:0] W_BRANCH     = cw(O,I,O,O,O,O,O,O,O,I,2'b00,2'b01,2'b01,I);
  localparam logic [16:0] W_JUMP       = cw(I,O,O,O,O,O,O,O,O,O,2'b00,2'b00,2'b10,I);
  localparam logic [16:0] W_ADDI_EXEC  = cw(O,O,O,O,O,O,O,O,O,I,2'b10,2'b00,2'b00,O);
  localparam logic [16:0] W_ADDI_WB    = cw(O,O,O,O,O,O,O,O,I,O,2'b00,2'b00,2'b00,I);

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [5:0] opcode = 6'd0;
  logic       zero = 1'b0;
  logic       mem_ready = 1'b1;
  logic       pc_write, pc_write_cond, ior_d, mem_read, mem_write, ir_write;
  logic       mem_to_reg, reg_dst, reg_write, alu_src_a, instr_done, mem_timeout;
  logic [1:0] alu_src_b, alu_op, pc_source;
`ifdef MC_ILLEGAL_TRAP_EN
  logic       illegal_op;
`endif

  int n_cmp = 0;
  int n_err = 0;
  logic [16:0] exp_q[$];
  string       tag_q[$];

  multicycle_control #(.MEM_TIMEOUT(4)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .opcode        (opcode),
    .zero          (zero),
    .mem_ready     (mem_ready),
    .pc_write      (pc_write),
    .pc_write_cond (pc_write_cond),
    .ior_d         (ior_d),
    .mem_read      (mem_read),
    .mem_write     (mem_write),
    .ir_write      (ir_write),
    .mem_to_reg    (mem_to_reg),
    .reg_dst       (reg_dst),
    .reg_write     (reg_write),
    .alu_src_a     (alu_src_a),
    .alu_src_b     (alu_src_b),
    .alu_op        (alu_op),
    .pc_source     (pc_source),
    .instr_done    (instr_done),
    .mem_timeout   (mem_timeout)
`ifdef MC_ILLEGAL_TRAP_EN
    ,
    .illegal_op    (illegal_op)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // Drive one cycle's inputs and queue the control word expected during that cycle.
  task automatic cyc(input logic rn, input logic rdy, input logic [5:0] op, input logic z,
                     input logic [16:0] e, input string tag);
    @(negedge clk);
    rst_n     = rn;
    mem_ready = rdy;
    opcode    = op;
    zero      = z;
    exp_q.push_back(e);
    tag_q.push_back(tag);
  endtask

  // Non-memory cycle: mem_ready is don't-care, so drive it randomly.
  task automatic cyc_any(input logic [5:0] op, input logic z, input logic [16:0] e,
                         input string tag);
    cyc(1'b1, 1'($urandom), op, z, e, tag);
  endtask

  task automatic chk_now(input string tag, input logic [31:0] obs_unused, input logic [31:0] exp);
    #2;
    chk(tag, 32'(mem_timeout), exp);
    if (obs_unused != 32'd0) begin end
  endtask

  // Expected-sequence model of one instruction starting in FETCH.
  task automatic run_instr(input logic [5:0] op, input logic z, input int fw, input int mw,
                           input string nm);
    for (int i = 0; i < fw; i++) cyc(1'b1, 1'b0, 6'($urandom), z, W_FETCH_WAIT, {nm, ".fetch_wait"});
    cyc(1'b1, 1'b1, 6'($urandom), z, W_FETCH_GO, {nm, ".fetch"});
    case (op)
      OP_LW: begin
        cyc_any(op, z, W_DECODE, {nm, ".decode"});
        cyc_any(op, z, W_MEM_ADDR, {nm, ".mem_addr"});
        for (int i = 0; i < mw; i++) cyc(1'b1, 1'b0, op, z, W_MEM_RD, {nm, ".mem_rd_wait"});
        cyc(1'b1, 1'b1, op, z, W_MEM_RD, {nm, ".mem_rd"});
        cyc_any(op, z, W_MEM_WB, {nm, ".mem_wb"});
      end
      OP_SW: begin
        cyc_any(op, z, W_DECODE, {nm, ".decode"});
        cyc_any(op, z, W_MEM_ADDR, {nm, ".mem_addr"});
        for (int i = 0; i < mw; i++) cyc(1'b1, 1'b0, op, z, W_MEM_WR, {nm, ".mem_wr_wait"});
        cyc(1'b1, 1'b1, op, z, W_MEM_WR_GO, {nm, ".mem_wr"});
      end
      OP_RTYPE: begin
        cyc_any(op, z, W_DECODE, {nm, ".decode"});
        cyc_any(op, z, W_R_EXEC, {nm, ".r_exec"});
        cyc_any(op, z, W_R_WB, {nm, ".r_wb"});
      end
      OP_BEQ: begin
        cyc_any(op, z, W_DECODE, {nm, ".decode"});
        cyc_any(op, z, W_BRANCH, {nm, ".branch"});
      end
      OP_J: begin
        cyc_any(op, z, W_DECODE, {nm, ".decode"});
        cyc_any(op, z, W_JUMP, {nm, ".jump"});
      end
      OP_ADDI: begin
        cyc_any(op, z, W_DECODE, {nm, ".decode"});
        cyc_any(op, z, W_ADDI_EXEC, {nm, ".addi_exec"});
        cyc_any(op, z, W_ADDI_WB, {nm, ".addi_wb"});
      end
      default: begin
`ifdef MC_ILLEGAL_TRAP_EN
        cyc_any(op, z, W_DECODE, {nm, ".decode"});
        for (int i = 0; i < 4; i++) begin
          cyc_any(6'($urandom), z, W_ZERO, {nm, ".trap"});
          #2;
          chk({nm, ".illegal_op"}, 32'(illegal_op), 32'd1);
        end
        cyc(1'b0, 1'b1, op, z, W_ZERO, {nm, ".trap_rst"});
        cyc(1'b1, 1'b1, op, z, W_ZERO, {nm, ".idle"});
        #2;
        chk({nm, ".illegal_op_clr"}, 32'(illegal_op), 32'd0);
`else
        cyc_any(op, z, W_DECODE_NOP, {nm, ".decode_nop"});
`endif
      end
    endcase
  endtask

  // Scoreboard: pop one expectation per queued cycle, compared mid low phase.
  always @(negedge clk) begin
    logic [16:0] e;
    logic [16:0] obs;
    string       t;
    #2;
    if (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      t = tag_q.pop_front();
      obs = {pc_write, pc_write_cond, ior_d, mem_read, mem_write, ir_write, mem_to_reg,
             reg_dst, reg_write, alu_src_a, alu_src_b, alu_op, pc_source, instr_done};
      chk(t, 32'(obs), 32'(e));
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (2) @(posedge clk);
    cyc(1'b0, 1'b1, OP_LW, 1'b0, W_ZERO, "reset_idle");
    chk_now("reset_timeout", 32'd0, 32'd0);
    cyc(1'b1, 1'b1, OP_LW, 1'b0, W_ZERO, "idle");

    run_instr(OP_LW,    1'b0, 0, 0, "lw");
    run_instr(OP_RTYPE, 1'b0, 0, 0, "rtype");
    run_instr(OP_BEQ,   1'b1, 0, 0, "beq_z1");
    run_instr(OP_BEQ,   1'b0, 0, 0, "beq_z0");
    run_instr(OP_J,     1'b0, 0, 0, "j");
    run_instr(OP_ADDI,  1'b0, 0, 0, "addi");
    run_instr(OP_ADDI,  1'b0, 3, 0, "addi_fw3");
    run_instr(OP_LW,    1'b0, 1, 2, "lw_stall");
    chk_now("no_timeout_short_waits", 32'd0, 32'd0);

    // sw stalled 10 cycles with MEM_TIMEOUT = 4
    cyc(1'b1, 1'b1, 6'($urandom), 1'b0, W_FETCH_GO, "sw_tmo.fetch");
    cyc_any(OP_SW, 1'b0, W_DECODE, "sw_tmo.decode");
    cyc_any(OP_SW, 1'b0, W_MEM_ADDR, "sw_tmo.mem_addr");
    for (int i = 0; i < 10; i++) begin
      cyc(1'b1, 1'b0, OP_SW, 1'b0, W_MEM_WR, "sw_tmo.wait");
      if (i == 3) chk_now("timeout_not_yet", 32'd0, 32'd0);
      if (i == 7) chk_now("timeout_set", 32'd0, 32'd1);
    end
    cyc(1'b1, 1'b1, OP_SW, 1'b0, W_MEM_WR_GO, "sw_tmo.mem_wr");
    run_instr(OP_J, 1'b0, 0, 0, "j_after_tmo");
    chk_now("timeout_sticky", 32'd0, 32'd1);

    run_instr(OP_BAD,   1'b0, 0, 0, "illegal");
    run_instr(OP_RTYPE, 1'b0, 0, 0, "rtype_after_illegal");

    // Reset while lw is stalled in MEM_READ
    cyc(1'b1, 1'b1, 6'($urandom), 1'b0, W_FETCH_GO, "lw_rst.fetch");
    cyc_any(OP_LW, 1'b0, W_DECODE, "lw_rst.decode");
    cyc_any(OP_LW, 1'b0, W_MEM_ADDR, "lw_rst.mem_addr");
    cyc(1'b1, 1'b0, OP_LW, 1'b0, W_MEM_RD, "lw_rst.mem_rd_wait");
    cyc(1'b0, 1'b0, OP_LW, 1'b0, W_MEM_RD, "lw_rst.mem_rd_in_reset");
    cyc(1'b1, 1'b1, OP_LW, 1'b0, W_ZERO, "lw_rst.idle");
    chk_now("timeout_cleared", 32'd0, 32'd0);
    run_instr(OP_SW, 1'b0, 0, 1, "sw_after_rst");

    repeat (3) @(negedge clk);
    #3;
    chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
